// File: rtl/timer_pkg.sv
// Shared types and defaults for the programmable timer.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_PS_WIDTH = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: one tick every div+1 clocks, restarted by clear.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PS_WIDTH = DEF_PS_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [PS_WIDTH-1:0] div,
  output logic                tick
);

  logic [PS_WIDTH-1:0] cnt_q;

  assign tick = (cnt_q == div);

  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable down-counting timer, one-shot or periodic.
// Optional tick prescaler enabled by TIMER_PRESCALER_EN.
module prog_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PS_WIDTH = DEF_PS_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                periodic,
  input  logic                start,
  input  logic                stop,
`ifdef TIMER_PRESCALER_EN
  input  logic [PS_WIDTH-1:0] prescale,
`endif
  output logic                out,
  output logic                busy,
  output logic [WIDTH-1:0]    count
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lval_q, lval_d;
  logic             mode_q, mode_d;
  logic             out_q, out_d;
  logic             tick;
  logic             kill, accept, adv, clear;

  // Mutually exclusive actions; stop outranks start and expiry.
  assign kill   = stop | (start & ~|load_val);
  assign accept = start & ~stop & |load_val;
  assign adv    = (state_q == RUN) & tick & ~start & ~stop;
  assign clear  = kill | accept;

`ifdef TIMER_PRESCALER_EN
  logic [PS_WIDTH-1:0] ps_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q <= '0;
    end else if (accept) begin
      ps_q <= prescale;
    end
  end

  timer_prescaler #(
    .PS_WIDTH(PS_WIDTH)
  ) u_pre (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .div  (ps_q),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lval_d  = lval_q;
    mode_d  = mode_q;
    out_d   = 1'b0;
    unique case (1'b1)
      kill: begin
        state_d = IDLE;
        count_d = '0;
      end
      accept: begin
        state_d = RUN;
        count_d = load_val;
        lval_d  = load_val;
        mode_d  = periodic;
      end
      adv: begin
        if (count_q > WIDTH'(1)) begin
          count_d = count_q - 1'b1;
        end else begin
          out_d = 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            count_d = lval_q;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      lval_q  <= '0;
      mode_q  <= MODE_ONESHOT;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lval_q  <= lval_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  assign out   = out_q;
  assign busy  = (state_q == RUN);
  assign count = count_q;

endmodule

// File: tb/tb_prog_timer.sv
// Randomised and directed bench for prog_timer against a
// start-time based reference model.
module tb_prog_timer;

  localparam int W   = 16;
  localparam int PSW = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] load_val;
  logic         periodic;
  logic         start;
  logic         stop;
  logic         out;
  logic         busy;
  logic [W-1:0] count;
  int           ps_in = 0;

`ifdef TIMER_PRESCALER_EN
  logic [PSW-1:0] prescale;
  assign prescale = ps_in[PSW-1:0];
`endif

  prog_timer #(
    .WIDTH(W),
    .PS_WIDTH(PSW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load_val(load_val),
    .periodic(periodic),
    .start   (start),
    .stop    (stop),
`ifdef TIMER_PRESCALER_EN
    .prescale(prescale),
`endif
    .out     (out),
    .busy    (busy),
    .count   (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: cycles elapsed since last accepted start drive everything.
  bit m_act;
  bit m_per;
  bit m_out;
  int m_t;
  int m_L;
  int m_P;
  int m_count;

  task automatic step();
    bit r  = reset;
    bit s  = start;
    bit p  = stop;
    bit pm = periodic;
    int ld = int'(load_val);
    int ps = ps_in;
    int ticks;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    m_out = 1'b0;
    if (r || p || (s && ld == 0)) begin
      m_act   = 1'b0;
      m_count = 0;
    end else if (s) begin
      m_act   = 1'b1;
      m_t     = 0;
      m_L     = ld;
      m_per   = pm;
      m_P     = ps;
      m_count = ld;
    end else if (m_act) begin
      m_t   = m_t + 1;
      ticks = m_t / (m_P + 1);
      if (m_t % (m_P + 1) == 0 && ticks % m_L == 0) begin
        m_out = 1'b1;
        if (m_per) begin
          m_count = m_L;
        end else begin
          m_act   = 1'b0;
          m_count = 0;
        end
      end else begin
        m_count = m_L - (ticks % m_L);
      end
    end
  endtask

  task automatic kick(input int ld, input bit pm);
    load_val = W'(ld);
    periodic = pm;
    start    = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (out !== 1'b0 || busy !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL reset_init out=%b busy=%b count=%0d want 0 0 0",
               out, busy, count);
    end
    kick(10, 1'b0);
    step();
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (out !== 1'b0 || busy !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL reset_mid out=%b busy=%b count=%0d want 0 0 0",
               out, busy, count);
    end
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (out !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_after cyc=%0d out=%b busy=%b want 0 0",
                 i, out, busy);
      end
    end
  endtask

  task automatic test_oneshot();
    int pulses = 0;
    int at     = -1;
    kick(5, 1'b0);
    step();
    for (int e = 1; e <= 20; e++) begin
      step();
      if (out === 1'b1) begin
        pulses++;
        at = e;
      end
      checks++;
      if (out !== m_out || busy !== m_act || count !== W'(m_count)) begin
        failures++;
        $display("FAIL oneshot e=%0d got %b/%b/%0d want %b/%b/%0d",
                 e, out, busy, count, m_out, m_act, m_count);
      end
    end
    checks++;
    if (pulses !== 1 || at !== 5) begin
      failures++;
      $display("FAIL oneshot_edge pulses=%0d at=%0d want 1 at 5",
               pulses, at);
    end
  endtask

  task automatic test_periodic();
    int pulses = 0;
    kick(4, 1'b1);
    step();
    for (int e = 1; e <= 14; e++) begin
      if (e == 10) stop = 1'b1;
      step();
      if (out === 1'b1) begin
        pulses++;
        checks++;
        if (e != 4 && e != 8) begin
          failures++;
          $display("FAIL periodic_pulse e=%0d got 1 want 0", e);
        end
      end
      checks++;
      if (out !== m_out || busy !== m_act || count !== W'(m_count)) begin
        failures++;
        $display("FAIL periodic e=%0d got %b/%b/%0d want %b/%b/%0d",
                 e, out, busy, count, m_out, m_act, m_count);
      end
    end
    checks++;
    if (pulses !== 2 || count !== '0) begin
      failures++;
      $display("FAIL periodic_stop pulses=%0d count=%0d want 2 0",
               pulses, count);
    end
    kick(1, 1'b1);
    step();
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (out !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL periodic_l1 e=%0d out=%b busy=%b want 1 1",
                 e, out, busy);
      end
    end
    stop = 1'b1;
    step();
  endtask

  task automatic test_restart();
    int at = -1;
    int pulses = 0;
    kick(8, 1'b0);
    step();
    for (int e = 1; e <= 12; e++) begin
      if (e == 3) kick(3, 1'b0);
      step();
      if (out === 1'b1) begin
        pulses++;
        at = e;
      end
      checks++;
      if (out !== m_out || busy !== m_act || count !== W'(m_count)) begin
        failures++;
        $display("FAIL restart e=%0d got %b/%b/%0d want %b/%b/%0d",
                 e, out, busy, count, m_out, m_act, m_count);
      end
    end
    checks++;
    if (pulses !== 1 || at !== 6) begin
      failures++;
      $display("FAIL restart_edge pulses=%0d at=%0d want 1 at 6",
               pulses, at);
    end
  endtask

  task automatic test_priority_zero();
    kick(7, 1'b1);
    stop = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL start_stop busy=%b count=%0d want 0 0",
               busy, count);
    end
    kick(0, 1'b0);
    step();
    step();
    checks++;
    if (busy !== 1'b0 || out !== 1'b0) begin
      failures++;
      $display("FAIL zero_load busy=%b out=%b want 0 0", busy, out);
    end
    kick(6, 1'b1);
    step();
    step();
    kick(0, 1'b1);
    step();
    checks++;
    if (busy !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL zero_restart busy=%b count=%0d want 0 0",
               busy, count);
    end
  endtask

`ifdef TIMER_PRESCALER_EN
  task automatic test_prescaler();
    int at = -1;
    int pulses = 0;
    ps_in = 2;
    kick(3, 1'b0);
    step();
    for (int e = 1; e <= 15; e++) begin
      step();
      if (out === 1'b1) begin
        pulses++;
        at = e;
      end
    end
    checks++;
    if (pulses !== 1 || at !== 9) begin
      failures++;
      $display("FAIL presc_oneshot pulses=%0d at=%0d want 1 at 9",
               pulses, at);
    end
    pulses = 0;
    kick(3, 1'b1);
    step();
    for (int e = 1; e <= 28; e++) begin
      step();
      if (out === 1'b1) begin
        pulses++;
        checks++;
        if (e % 9 != 0) begin
          failures++;
          $display("FAIL presc_periodic e=%0d got 1 want 0", e);
        end
      end
    end
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL presc_count pulses=%0d want 3", pulses);
    end
    stop = 1'b1;
    step();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 24) == 0);
      load_val = W'($urandom_range(0, 9));
      periodic = 1'($urandom_range(0, 1));
`ifdef TIMER_PRESCALER_EN
      ps_in = int'($urandom_range(0, 3));
`endif
      step();
      reset = 1'b0;
      checks++;
      if (out !== m_out || busy !== m_act || count !== W'(m_count)) begin
        failures++;
        $display("FAIL random i=%0d got %b/%b/%0d want %b/%b/%0d",
                 i, out, busy, count, m_out, m_act, m_count);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    periodic = 1'b0;
    load_val = '0;
    m_act    = 1'b0;
    m_per    = 1'b0;
    m_out    = 1'b0;
    m_t      = 0;
    m_L      = 1;
    m_P      = 0;
    m_count  = 0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_restart();
    test_priority_zero();
`ifdef TIMER_PRESCALER_EN
    test_prescaler();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
# prog_timer

Parametrised programmable down-counting timer. It generalises the fixed single-output timer to a configurable count width, one-shot or periodic mode, and start/stop control. It sits beside the system control logic as a reusable timebase and delivers one-cycle expiry pulses to any block that needs a programmable delay or a periodic tick.

## Interface
Parameters:
- WIDTH, 16, width of load value and counter (≥2)
- PS_WIDTH, 8, width of prescale input (used only with TIMER_PRESCALER_EN)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- load_val  input  WIDTH  terminal count L, sampled on accepted start
- periodic  input  1  mode sampled on accepted start: 0 = one-shot, 1 = periodic
- start  input  1  single-cycle request to (re)start the timer
- stop  input  1  single-cycle request to abort
- prescale  input  PS_WIDTH  tick divider P (present only with TIMER_PRESCALER_EN)
- out  output  1  registered expiry pulse, one clk wide
- busy  output  1  high while in RUN
- count  output  WIDTH  current remaining count

## Operation
- States: IDLE, RUN. Reset state is IDLE.
- Reset values: out=0, busy=0, count=0. The latched load value, latched mode, and prescaler counter are all 0.
- IDLE, start=1, load_val≠0: latch load_val and periodic, set count=L, go to RUN.
- IDLE, start=1, load_val=0: ignored; remain in IDLE.
- RUN, on each tick, count>1: count decrements by 1.
- RUN, on a tick with count==1: out=1 for the next cycle.
  - Periodic mode: count reloads to the latched L and the block stays in RUN.
  - One-shot mode: count becomes 0 and the block goes to IDLE.
- RUN, start=1 (no stop): restart. Re-latch load_val and periodic, set count=L, clear the prescaler. A pending expiry on the same edge is discarded (out=0). If load_val=0, behave as stop.
- stop=1 in any state: go to IDLE, count=0, out=0. stop has priority over start and over expiry on the same edge.
- Synchronous reset overrides everything, including mid-count.
- Arithmetic is unsigned. count never wraps below 0.

## Timing
- Without the prescaler, tick is 1 every clk.
- With start sampled at edge 0, count=L after edge 0. Edge L produces expiry, so out is high during the cycle following edge L. Start-to-out latency is L clk cycles.
- Periodic mode: out pulses every L cycles with no gap cycle. L=1 gives out high continuously while in RUN.
- busy rises the cycle after an accepted start. In one-shot mode it falls in the same cycle that out is high.
- count and out are both registered; there is no combinational input-to-output path.

## Configuration
- Macro: TIMER_PRESCALER_EN.
- Defined:
  - The prescale port exists and is sampled on an accepted start.
  - One tick occurs every P+1 clk cycles. The prescaler counter clears on start, restart, stop, and reset.
  - Start-to-out latency is L·(P+1) cycles. Periodic period is L·(P+1).
- Undefined:
  - The prescale port and prescaler logic are absent.
  - Tick is tied to 1.

## Structure
- Package timer_pkg holds:
  - state enum (IDLE, RUN)
  - mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1)
  - default WIDTH and PS_WIDTH constants
- Sub-module timer_prescaler, instantiated only under TIMER_PRESCALER_EN. Ports: clk, reset, clear, div[PS_WIDTH], tick out.
- Top prog_timer holds the FSM, the counter, and the load/mode latches.

## Test plan
- Reset: reset high 2 cycles mid-RUN (L=10) → next cycle out=0, busy=0, count=0; no later pulse.
- One-shot, macro off, L=5: start at edge 0 → out high exactly in the cycle after edge 5; busy low from then; no further pulses over 20 cycles.
- Periodic, L=4: out pulses at edges 4, 8, 12, each one cycle wide. stop at edge 10 → no pulse at 12, count=0.
- Restart: L=8 started; at edge 3 start with L=3 → pulse after edge 6, none after edge 8.
- Priority and zero load: start+stop on the same edge in IDLE → stays IDLE. start with load_val=0 → busy stays 0.
- Macro on, P=2, L=3, one-shot: out high after edge 9. Periodic mode gives pulses every 9 cycles.
